icache_ctrl: RTL and testbench

- Direct-mapped instruction cache sitting between the core's fetch stage and the memory controller's per-CPU instruction port.
- Serves hits combinationally.
- On a miss it issues a single-word read request on the iREN/iaddr bus, holds it until the controller drops iwait, then fills the frame.
- One instance per CPU.

---
 rtl/cpu_types_pkg.sv | 21 ++
 rtl/icache_array.sv | 55 +++++
 rtl/icache_ctrl.sv | 131 +++++++++++++
 tb/tb_icache_ctrl.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU types: icache frame, icache address view, icache FSM states
package cpu_types_pkg;
  localparam int CPU_WORD_W   = 32;
  localparam int ICACHE_SETS  = 16;
  localparam int ICACHE_IDX_W = $clog2(ICACHE_SETS);
  localparam int ICACHE_TAG_W = CPU_WORD_W - ICACHE_IDX_W - 2;

  typedef struct packed {
    logic                    valid;
    logic [ICACHE_TAG_W-1:0] tag;
    logic [CPU_WORD_W-1:0]   data;
  } icache_frame_t;

  typedef struct packed {
    logic [ICACHE_TAG_W-1:0] tag;
    logic [ICACHE_IDX_W-1:0] idx;
    logic [1:0]              offset;
  } icachef_t;

  typedef enum logic { IDLE = 1'b0, FETCH = 1'b1 } icache_state_t;
endpackage

// File: rtl/icache_array.sv
// rtl/icache_array.sv - direct-mapped icache frame storage: synchronous write, combinational read, flush-all
module icache_array
  import cpu_types_pkg::*;
#(
  parameter int SETS   = ICACHE_SETS,
  parameter int TAG_W  = ICACHE_TAG_W,
  parameter int DATA_W = CPU_WORD_W
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    flush_all,
  input  logic [$clog2(SETS)-1:0] rd_idx,
  output logic                    rd_valid,
  output logic [TAG_W-1:0]        rd_tag,
  output logic [DATA_W-1:0]       rd_data,
  input  logic                    wr_en,
  input  logic [$clog2(SETS)-1:0] wr_idx,
  input  logic [TAG_W-1:0]        wr_tag,
  input  logic [DATA_W-1:0]       wr_data
);
  logic [SETS-1:0]   valid_q, valid_d;
  logic [TAG_W-1:0]  tag_q  [SETS];
  logic [TAG_W-1:0]  tag_d  [SETS];
  logic [DATA_W-1:0] data_q [SETS];
  logic [DATA_W-1:0] data_d [SETS];

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_data  = data_q[rd_idx];

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (wr_en) begin
      valid_d[wr_idx] = 1'b1;
      tag_d[wr_idx]   = wr_tag;
      data_d[wr_idx]  = wr_data;
    end
    // flush wins over a same-cycle fill
    if (flush_all) begin
      valid_d = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
    tag_q  <= tag_d;
    data_q <= data_d;
  end
endmodule

// File: rtl/icache_ctrl.sv
// rtl/icache_ctrl.sv - direct-mapped instruction cache controller (IDLE/FETCH miss FSM)
// Optional hit/miss counters enabled by ICACHE_PERF_EN.
module icache_ctrl
  import cpu_types_pkg::*;
#(
  parameter int SETS   = ICACHE_SETS,
  parameter int WORD_W = CPU_WORD_W
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              imemREN,
  input  logic [WORD_W-1:0] imemaddr,
  input  logic              flush,
  output logic              ihit,
  output logic [WORD_W-1:0] imemload,
  output logic              iREN,
  output logic [WORD_W-1:0] iaddr,
  input  logic              iwait,
  input  logic [WORD_W-1:0] iload
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
`endif
);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = WORD_W - IDX_W - 2;

  icache_state_t     state_q, state_d;
  logic [WORD_W-1:0] miss_addr_q, miss_addr_d;
  logic              drop_q, drop_d;

  logic [IDX_W-1:0]  rd_idx, wr_idx;
  logic [TAG_W-1:0]  req_tag, wr_tag, frame_tag;
  logic [WORD_W-1:0] frame_data;
  logic              frame_valid, hit, wr_en;

  assign rd_idx  = imemaddr[IDX_W+1:2];
  assign req_tag = imemaddr[WORD_W-1:IDX_W+2];
  assign wr_idx  = miss_addr_q[IDX_W+1:2];
  assign wr_tag  = miss_addr_q[WORD_W-1:IDX_W+2];
  assign hit     = frame_valid && (frame_tag == req_tag);

  icache_array #(
    .SETS   (SETS),
    .TAG_W  (TAG_W),
    .DATA_W (WORD_W)
  ) u_array (
    .CLK       (CLK),
    .RST       (RST),
    .flush_all (flush),
    .rd_idx    (rd_idx),
    .rd_valid  (frame_valid),
    .rd_tag    (frame_tag),
    .rd_data   (frame_data),
    .wr_en     (wr_en),
    .wr_idx    (wr_idx),
    .wr_tag    (wr_tag),
    .wr_data   (iload)
  );

  always_comb begin
    state_d     = state_q;
    miss_addr_d = miss_addr_q;
    drop_d      = drop_q;
    ihit        = 1'b0;
    imemload    = '0;
    iREN        = 1'b0;
    iaddr       = '0;
    wr_en       = 1'b0;
    case (state_q)
      IDLE: begin
        ihit = imemREN && hit && !flush;
        if (ihit) begin
          imemload = frame_data;
        end
        if (imemREN && !hit && !flush) begin
          miss_addr_d = imemaddr & ~WORD_W'(3);
          state_d     = FETCH;
        end
      end
      FETCH: begin
        iREN  = 1'b1;
        iaddr = miss_addr_q;
        // a flush seen at any point of the request poisons its returned word
        if (!iwait) begin
          wr_en   = !drop_q && !flush;
          drop_d  = 1'b0;
          state_d = IDLE;
        end else if (flush) begin
          drop_d = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      miss_addr_q <= '0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      miss_addr_q <= miss_addr_d;
      drop_q      <= drop_d;
    end
  end

`ifdef ICACHE_PERF_EN
  logic [31:0] hit_count_q, hit_count_d;
  logic [31:0] miss_count_q, miss_count_d;

  always_comb begin
    hit_count_d  = hit_count_q + {31'd0, ihit};
    miss_count_d = miss_count_q + {31'd0, (state_q == IDLE) && (state_d == FETCH)};
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`endif
endmodule

// File: tb/tb_icache_ctrl.sv
// tb/tb_icache_ctrl.sv - scoreboard bench for icache_ctrl: directed plan plus randomized accesses
module tb_icache_ctrl;
  logic        CLK, RST, imemREN, flush, ihit, iREN, iwait;
  logic [31:0] imemaddr, imemload, iaddr, iload;
`ifdef ICACHE_PERF_EN
  logic [31:0] hit_count, miss_count;
`endif

  icache_ctrl dut (
    .CLK      (CLK),
    .RST      (RST),
    .imemREN  (imemREN),
    .imemaddr (imemaddr),
    .flush    (flush),
    .ihit     (ihit),
    .imemload (imemload),
    .iREN     (iREN),
    .iaddr    (iaddr),
    .iwait    (iwait),
    .iload    (iload)
`ifdef ICACHE_PERF_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  typedef struct {
    int          cyc;
    logic [31:0] val;
    int          len;
  } ev_t;

  ev_t         hit_q[$];
  ev_t         req_q[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  bit          mon_en = 0;
  int          n_hit = 0;
  int          n_miss = 0;
  logic [29:0] resident [int];
  logic [31:0] mem [logic [31:0]];

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] wa);
    if (mem.exists(wa)) return mem[wa];
    return (wa * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  function automatic int slot(input logic [31:0] a);
    return int'(a[5:2]);
  endfunction

  function automatic bit is_resident(input logic [31:0] a);
    return resident.exists(slot(a)) && resident[slot(a)] == a[31:2];
  endfunction

  function automatic logic [31:0] rand_addr();
    logic [31:0] r;
    int          t;
    t = $urandom_range(0, 2);
    r = $urandom;
    r[31:6] = (t == 0) ? 26'd0 : (t == 1) ? 26'd1 : 26'h3FF_FFFF;
    return r;
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic model_reset();
    resident.delete();
    n_hit  = 0;
    n_miss = 0;
  endtask

  // One fetch as the core sees it: repeat until the word is delivered, acting as memory on misses.
  task automatic access(input logic [31:0] a, input int w_in, input int flush_at_in,
                        input int rst_at_in, input bit perturb);
    int          w, len, iter, flush_at, rst_at;
    bit          done, dropped, was_reset;
    logic [31:0] wa;
    wa       = a & 32'hFFFF_FFFC;
    flush_at = flush_at_in;
    rst_at   = rst_at_in;
    done     = 0;
    iter     = 0;
    while (!done && iter < 5) begin
      iter++;
      imemREN = 1'b1; imemaddr = a; flush = 1'b0; RST = 1'b0; iwait = 1'b1;
      if (is_resident(a)) begin
        hit_q.push_back('{cyc, mem_word(wa), 0});
        n_hit++;
        step();
        done = 1;
      end else begin
        w   = (w_in >= 0) ? w_in : int'($urandom_range(0, 3));
        len = (rst_at >= 0 && rst_at <= w) ? rst_at + 1 : w + 1;
        n_miss++;
        step();
        req_q.push_back('{cyc, wa, len});
        dropped   = 0;
        was_reset = 0;
        for (int j = 0; j <= w && !was_reset; j++) begin
          iwait = (j < w);
          iload = (j == w) ? mem_word(wa) : $urandom;
          flush = (j == flush_at);
          RST   = (j == rst_at);
          if (perturb) begin
            imemREN  = 1'($urandom);
            imemaddr = $urandom;
          end
          if (RST) begin
            model_reset();
            was_reset = 1;
          end else begin
            if (flush) begin
              resident.delete();
              dropped = 1;
            end
            if (j == w && !dropped) resident[slot(a)] = wa[31:2];
          end
          step();
        end
        RST = 1'b0; flush = 1'b0; iwait = 1'b1;
        flush_at = -1;
        rst_at   = -1;
      end
    end
    imemREN = 1'b0;
  endtask

  task automatic flush_idle(input logic [31:0] a);
    imemREN = 1'b1; imemaddr = a; flush = 1'b1;
    resident.delete();
    step();
    flush = 1'b0; imemREN = 1'b0;
  endtask

  task automatic idle(input int n);
    imemREN = 1'b0;
    repeat (n) step();
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a hit or starts a request.
  initial begin
    ev_t         e;
    bit          ren_prev;
    int          run, cur_len;
    logic [31:0] cur_addr;
    ren_prev = 0; run = 0; cur_len = 0; cur_addr = '0;
    forever begin
      @(negedge CLK);
      if (mon_en) begin
        if (iREN && !ren_prev) begin
          chk(req_q.size() != 0, "req_expected", iaddr, 32'h0);
          if (req_q.size() != 0) begin
            e = req_q.pop_front();
            chk(e.cyc == cyc, "req_cycle", cyc, e.cyc);
            cur_addr = e.val;
            cur_len  = e.len;
          end else begin
            cur_addr = iaddr;
            cur_len  = 0;
          end
          run = 0;
        end
        if (iREN) begin
          run++;
          chk(iaddr == cur_addr, "iaddr", iaddr, cur_addr);
        end else if (ren_prev) begin
          chk(run == cur_len, "req_len", run, cur_len);
        end
        if (ihit) begin
          chk(hit_q.size() != 0, "hit_expected", imemaddr, 32'h0);
          chk(!iREN, "hit_with_iren", {31'd0, iREN}, 32'h0);
          if (hit_q.size() != 0) begin
            e = hit_q.pop_front();
            chk(e.cyc == cyc, "hit_cycle", cyc, e.cyc);
            chk(imemload == e.val, "imemload", imemload, e.val);
          end
        end else begin
          chk(imemload == 32'h0, "imemload_nohit", imemload, 32'h0);
        end
        if (hit_q.size() != 0) begin
          chk(hit_q[0].cyc >= cyc, "hit_missing", cyc, hit_q[0].cyc);
          if (hit_q[0].cyc < cyc) void'(hit_q.pop_front());
        end
        if (req_q.size() != 0) begin
          chk(req_q[0].cyc >= cyc, "req_missing", cyc, req_q[0].cyc);
          if (req_q[0].cyc < cyc) void'(req_q.pop_front());
        end
        ren_prev = iREN;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    RST = 1'b1; imemREN = 1'b0; imemaddr = '0; flush = 1'b0; iwait = 1'b1; iload = '0;
    mem[32'h0000_0040] = 32'hDEAD_BEEF;
    mem[32'h0000_0080] = 32'h1234_5678;
    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b0;
    @(negedge CLK);
    chk(ihit == 1'b0, "reset_ihit", {31'd0, ihit}, 32'h0);
    chk(iREN == 1'b0, "reset_iREN", {31'd0, iREN}, 32'h0);
    chk(iaddr == 32'h0, "reset_iaddr", iaddr, 32'h0);
    chk(imemload == 32'h0, "reset_imemload", imemload, 32'h0);
`ifdef ICACHE_PERF_EN
    chk(hit_count == 32'h0, "reset_hit_count", hit_count, 32'h0);
    chk(miss_count == 32'h0, "reset_miss_count", miss_count, 32'h0);
`endif
    step();
    mon_en = 1;

    access(32'h40, 3, -1, -1, 0);
    access(32'h40, 0, -1, -1, 0);
    access(32'h04, 1, -1, -1, 0);
    access(32'h44, 2, -1, -1, 0);
    access(32'h04, 0, -1, -1, 0);
    for (int i = 0; i < 4; i++) access(32'(i * 4), 1, -1, -1, 0);
    flush_idle(32'h4);
    for (int i = 0; i < 4; i++) access(32'(i * 4), 0, -1, -1, 0);
    access(32'h80, 2, 1, -1, 0);
    access(32'h88, 2, 2, -1, 0);
    access(32'h100, 3, -1, 1, 0);
    access(32'h40, 1, -1, -1, 1);
    access(32'h44, 0, -1, -1, 0);

    RST = 1'b1;
    model_reset();
    step();
    RST = 1'b0;
`ifdef ICACHE_PERF_EN
    chk(hit_count == 32'h0, "rst_hit_count", hit_count, 32'h0);
    chk(miss_count == 32'h0, "rst_miss_count", miss_count, 32'h0);
`endif
    repeat (5) access(32'h40, 1, -1, -1, 0);
`ifdef ICACHE_PERF_EN
    chk(hit_count == 32'd5, "perf_hit_count", hit_count, 32'd5);
    chk(miss_count == 32'd1, "perf_miss_count", miss_count, 32'd1);
`endif

    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 99);
      if (r < 5) flush_idle(rand_addr());
      else if (r < 10) idle($urandom_range(1, 3));
      else access(rand_addr(), -1,
                  ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 3)) : -1,
                  ($urandom_range(0, 29) == 0) ? int'($urandom_range(0, 3)) : -1,
                  $urandom_range(0, 3) == 0);
    end

    idle(4);
    chk(hit_q.size() == 0, "hits_pending", 32'(hit_q.size()), 32'h0);
    chk(req_q.size() == 0, "reqs_pending", 32'(req_q.size()), 32'h0);
`ifdef ICACHE_PERF_EN
    chk(hit_count == 32'(n_hit), "final_hit_count", hit_count, 32'(n_hit));
    chk(miss_count == 32'(n_miss), "final_miss_count", miss_count, 32'(n_miss));
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
